bram_16384x1_arbiter: RTL

- Shares one dual-port 16384x1 bit BRAM wrapper between NREQ requesters.
- Owns both BRAM ports. After reset it optionally zero-clears the whole array, using both ports in parallel.
- In normal operation it grants up to two requests per cycle: one on port 0, one on port 1.
- Arbitration is round-robin, requests use a valid/ready handshake, and each read returns its data on a per-requester response strobe one cycle after grant.

---
 rtl/bram_16384x1_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bram_16384x1_arbiter.sv
// Round-robin arbiter that shares one dual-port 16384x1 BRAM among NREQ requesters.
// After reset it can zero-clear the whole array, using both ports in parallel.
module bram_16384x1_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned AW             = 14,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ-1:0]    rsp_rdata,
    output logic               init_done,
    output logic [AW-1:0]      A0,
    output logic [AW-1:0]      A1,
    output logic               D0,
    output logic               D1,
    output logic               WE0,
    output logic               WE1,
    output logic               WEM0,
    output logic               WEM1,
    output logic               CE0,
    output logic               CE1,
    input  logic               Q0,
    input  logic               Q1
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = AW - 1;
    localparam logic [CW-1:0] CLR_LAST = '1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state;
    logic [CW-1:0]   clr_cnt;
    logic [PW-1:0]   ptr;
    logic            t0_v, t1_v;
    logic [PW-1:0]   t0_id, t1_id;
    logic [AW-1:0]   a0_hold, a1_hold;
    logic            d0_hold, d1_hold;
    logic [NREQ-1:0] rdata_hold;

    logic [AW-1:0]   addr_a [NREQ];
    logic            g0_v, g1_v, g1_ok;
    logic [PW-1:0]   g0, g1, last_g, next_ptr;
    int              idx;

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_addr
        assign addr_a[i] = req_addr[i*AW +: AW];
    end

    // First and second valid requester in round-robin order starting at ptr
    always_comb begin
        g0_v = 1'b0;
        g1_v = 1'b0;
        g0   = '0;
        g1   = '0;
        idx  = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (req_valid[PW'(idx)]) begin
                if (!g0_v) begin
                    g0_v = 1'b1;
                    g0   = PW'(idx);
                end else if (!g1_v) begin
                    g1_v = 1'b1;
                    g1   = PW'(idx);
                end
            end
        end
    end

    // Second grant is withheld when it would touch the same address as a write
    assign g1_ok    = g1_v && !((addr_a[g0] == addr_a[g1]) && (req_we[g0] || req_we[g1]));
    assign last_g   = g1_ok ? g1 : g0;
    assign next_ptr = (last_g == PW'(NREQ - 1)) ? '0 : last_g + PW'(1);

    // BRAM port and ready driving; everything is forced low while reset is held
    always_comb begin
        req_ready = '0;
        CE0       = 1'b0;
        CE1       = 1'b0;
        WE0       = 1'b0;
        WE1       = 1'b0;
        A0        = a0_hold;
        A1        = a1_hold;
        D0        = d0_hold;
        D1        = d1_hold;
        if (!RSTN) begin
            A0 = '0;
            A1 = '0;
            D0 = 1'b0;
            D1 = 1'b0;
        end else if (state == S_CLEAR) begin
            CE0 = 1'b1;
            CE1 = 1'b1;
            WE0 = 1'b1;
            WE1 = 1'b1;
            D0  = 1'b0;
            D1  = 1'b0;
            A0  = {1'b0, clr_cnt};
            A1  = {1'b1, clr_cnt};
        end else begin
            if (g0_v) begin
                req_ready[g0] = 1'b1;
                CE0 = 1'b1;
                WE0 = req_we[g0];
                A0  = addr_a[g0];
                D0  = req_wdata[g0];
            end
            if (g1_ok) begin
                req_ready[g1] = 1'b1;
                CE1 = 1'b1;
                WE1 = req_we[g1];
                A1  = addr_a[g1];
                D1  = req_wdata[g1];
            end
        end
    end

    assign WEM0 = WE0;
    assign WEM1 = WE1;

    // Read data is routed to the tagged requester the cycle after its grant
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = rdata_hold;
        if (t0_v) begin
            rsp_valid[t0_id] = 1'b1;
            rsp_rdata[t0_id] = Q0;
        end
        if (t1_v) begin
            rsp_valid[t1_id] = 1'b1;
            rsp_rdata[t1_id] = Q1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt    <= '0;
            ptr        <= '0;
            init_done  <= 1'b0;
            t0_v       <= 1'b0;
            t1_v       <= 1'b0;
            t0_id      <= '0;
            t1_id      <= '0;
            a0_hold    <= '0;
            a1_hold    <= '0;
            d0_hold    <= 1'b0;
            d1_hold    <= 1'b0;
            rdata_hold <= '0;
        end else begin
            a0_hold    <= A0;
            a1_hold    <= A1;
            d0_hold    <= D0;
            d1_hold    <= D1;
            rdata_hold <= rsp_rdata;
            t0_v       <= 1'b0;
            t1_v       <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + CW'(1);
                    if (clr_cnt == CLR_LAST) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    if (g0_v) begin
                        t0_v  <= ~req_we[g0];
                        t0_id <= g0;
                        t1_v  <= g1_ok & ~req_we[g1];
                        t1_id <= g1;
                        ptr   <= next_ptr;
                    end
                end
            endcase
        end
    end
endmodule
